// File: rtl/spu_fwd_pkg.sv
// Shared types and constants for the SPU forwarding scoreboard.
// The per-stage entry record is common to the tracker and the per-operand selectors.
package spu_fwd_pkg;

  localparam int SPU_REG_AW = 7;
  localparam int SPU_LAT_W  = 4;

  localparam int SRC_RA = 0;
  localparam int SRC_RB = 1;
  localparam int SRC_RC = 2;

  typedef struct packed {
    logic                  valid;
    logic [SPU_REG_AW-1:0] dst;
    logic [SPU_LAT_W-1:0]  lat;
  } entry_t;

  // Width of a pipe index; a single pipe still gets one bit.
  function automatic int pipe_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spu_fwd_if.sv
// Issue/operand-select bundle between decode/issue (master) and the scoreboard (slave).
interface spu_fwd_if #(
  parameter int NUM_PIPES = 2,
  parameter int NUM_SRC   = 3,
  parameter int REG_AW    = 7,
  parameter int LAT_W     = 4,
  parameter int PW        = 1,
  parameter int SW        = 3
);
  logic                                         stall_in;
  logic                                         flush;
  logic [NUM_PIPES-1:0]                         issue_valid;
  logic [NUM_PIPES-1:0]                         issue_wr;
  logic [NUM_PIPES-1:0][REG_AW-1:0]             issue_dst;
  logic [NUM_PIPES-1:0][LAT_W-1:0]              issue_lat;
  logic [NUM_PIPES-1:0][NUM_SRC-1:0]            src_valid;
  logic [NUM_PIPES-1:0][NUM_SRC-1:0][REG_AW-1:0] src_reg;
  logic [NUM_PIPES-1:0][NUM_SRC-1:0]            fw_hit;
  logic [NUM_PIPES-1:0][NUM_SRC-1:0][PW-1:0]    fw_pipe;
  logic [NUM_PIPES-1:0][NUM_SRC-1:0][SW-1:0]    fw_stage;
  logic                                         hazard_stall;

  modport master (
    output stall_in, flush, issue_valid, issue_wr, issue_dst, issue_lat, src_valid, src_reg,
    input  fw_hit, fw_pipe, fw_stage, hazard_stall
  );

  modport slave (
    input  stall_in, flush, issue_valid, issue_wr, issue_dst, issue_lat, src_valid, src_reg,
    output fw_hit, fw_pipe, fw_stage, hazard_stall
  );
endinterface

// File: rtl/spu_fwd_sel.sv
// Youngest-match priority encoder for one source operand over all tracked entries.
// Reports a forward hit when the youngest match is ready, blocked when it is not.
module spu_fwd_sel
  import spu_fwd_pkg::*;
#(
  parameter int NUM_PIPES = 2,
  parameter int DEPTH     = 7,
  parameter int REG_AW    = SPU_REG_AW,
  parameter int PW        = 1,
  parameter int SW        = 3
) (
  input  entry_t [DEPTH-1:0][NUM_PIPES-1:0] ents,
  input  logic                              src_valid,
  input  logic [REG_AW-1:0]                 src_reg,
  output logic                              hit,
  output logic [PW-1:0]                     pipe,
  output logic [SW-1:0]                     stage,
  output logic                              blocked
);

  logic          found;
  logic          rdy;
  logic [PW-1:0] sel_p;
  logic [SW-1:0] sel_s;

  // Scan oldest to youngest so the last match written is the youngest:
  // lower stage wins, and within a stage the higher (odd) pipe wins.
  always_comb begin
    found = 1'b0;
    rdy   = 1'b0;
    sel_p = '0;
    sel_s = '0;
    for (int s = DEPTH - 1; s >= 0; s--) begin
      for (int p = 0; p < NUM_PIPES; p++) begin
        if (src_valid && ents[s][p].valid && (ents[s][p].dst == src_reg)) begin
          found = 1'b1;
          rdy   = (int'(ents[s][p].lat) <= s + 1);
          sel_p = PW'(p);
          sel_s = SW'(s + 1);
        end
      end
    end
  end

  assign hit     = found & rdy;
  assign blocked = found & ~rdy;
  assign pipe    = hit ? sel_p : '0;
  assign stage   = hit ? sel_s : '0;

endmodule

// File: rtl/spu_fwd_scoreboard.sv
// Forwarding scoreboard: age-ordered tracker of in-flight RF writes plus per-operand select.
// Optional stall statistics counter enabled by SPU_FWD_SB_STATS_EN.
module spu_fwd_scoreboard
  import spu_fwd_pkg::*;
#(
  parameter int NUM_PIPES   = 2,
  parameter int DEPTH       = 7,
  parameter int NUM_SRC     = 3,
  parameter int REG_AW      = SPU_REG_AW,
  parameter int LAT_W       = SPU_LAT_W,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  spu_fwd_if.slave    bus
`ifdef SPU_FWD_SB_STATS_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int PW = pipe_w(NUM_PIPES);
  localparam int SW = $clog2(DEPTH + 1);

  // Index s holds stage s+1; index 0 is the youngest stage.
  entry_t [DEPTH-1:0][NUM_PIPES-1:0] ents, ents_nxt;

  logic [NUM_PIPES-1:0][NUM_SRC-1:0]         hit;
  logic [NUM_PIPES-1:0][NUM_SRC-1:0][PW-1:0] fpipe;
  logic [NUM_PIPES-1:0][NUM_SRC-1:0][SW-1:0] fstage;
  logic [NUM_PIPES-1:0][NUM_SRC-1:0]         blocked;
  logic                                      hazard;
  int                                        kill_n;

  assign hazard = |blocked;

  always_comb begin
    ents_nxt = ents;
    kill_n   = 0;
    if (!bus.stall_in) begin
      for (int s = DEPTH - 1; s > 0; s--)
        ents_nxt[s] = ents[s-1];
      for (int p = 0; p < NUM_PIPES; p++) begin
        ents_nxt[0][p].valid = bus.issue_valid[p] & bus.issue_wr[p] & ~hazard & ~bus.flush;
        ents_nxt[0][p].dst   = bus.issue_dst[p][REG_AW-1:0];
        ents_nxt[0][p].lat   = bus.issue_lat[p][LAT_W-1:0];
      end
    end
    // Flushed stages 1..FLUSH_DEPTH occupy one more slot once they have shifted.
    if (bus.flush)
      kill_n = bus.stall_in ? FLUSH_DEPTH : FLUSH_DEPTH + 1;
    for (int s = 0; s < DEPTH; s++)
      if (s < kill_n)
        for (int p = 0; p < NUM_PIPES; p++)
          ents_nxt[s][p].valid = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ents <= '0;
    else        ents <= ents_nxt;
  end

  for (genvar p = 0; p < NUM_PIPES; p++) begin : g_pipe
    for (genvar r = 0; r < NUM_SRC; r++) begin : g_src
      spu_fwd_sel #(
        .NUM_PIPES (NUM_PIPES),
        .DEPTH     (DEPTH),
        .REG_AW    (REG_AW),
        .PW        (PW),
        .SW        (SW)
      ) u_sel (
        .ents      (ents),
        .src_valid (bus.src_valid[p][r]),
        .src_reg   (bus.src_reg[p][r]),
        .hit       (hit[p][r]),
        .pipe      (fpipe[p][r]),
        .stage     (fstage[p][r]),
        .blocked   (blocked[p][r])
      );
    end
  end

  assign bus.fw_hit       = hit;
  assign bus.fw_pipe      = fpipe;
  assign bus.fw_stage     = fstage;
  assign bus.hazard_stall = hazard;

`ifdef SPU_FWD_SB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (hazard && !bus.stall_in && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_spu_fwd_scoreboard.sv
// Scoreboard bench for spu_fwd_scoreboard: each scenario pushes expected operand results
// when it drives stimulus and pops/compares them against the combinational outputs.
module tb_spu_fwd_scoreboard;
  import spu_fwd_pkg::*;

  localparam int NP = 2;
  localparam int D  = 7;
  localparam int NS = 3;
  localparam int AW = 7;
  localparam int LW = 4;
  localparam int FD = 2;
  localparam int PW = (NP > 1) ? $clog2(NP) : 1;
  localparam int SW = $clog2(D + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spu_fwd_if #(.NUM_PIPES(NP), .NUM_SRC(NS), .REG_AW(AW), .LAT_W(LW), .PW(PW), .SW(SW)) bus ();

`ifdef SPU_FWD_SB_STATS_EN
  logic [31:0] stall_cnt;
`endif

  spu_fwd_scoreboard #(
    .NUM_PIPES(NP), .DEPTH(D), .NUM_SRC(NS), .REG_AW(AW), .LAT_W(LW), .FLUSH_DEPTH(FD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus)
`ifdef SPU_FWD_SB_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct {
    string          nm;
    int             p;
    int             r;
    logic           hit;
    logic [PW-1:0]  pipe;
    logic [SW-1:0]  stage;
    logic           stall;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_cnt = '0;
  logic        cyc_stall = 1'b0;

  task automatic clr();
    bus.stall_in    = 1'b0;
    bus.flush       = 1'b0;
    bus.issue_valid = '0;
    bus.issue_wr    = '0;
    bus.issue_dst   = '0;
    bus.issue_lat   = '0;
    bus.src_valid   = '0;
    bus.src_reg     = '0;
  endtask

  task automatic issue(input int p, input int dst, input int lat);
    bus.issue_valid[p] = 1'b1;
    bus.issue_wr[p]    = 1'b1;
    bus.issue_dst[p]   = AW'(dst);
    bus.issue_lat[p]   = LW'(lat);
  endtask

  task automatic rd(input int p, input int r, input int rg);
    bus.src_valid[p][r] = 1'b1;
    bus.src_reg[p][r]   = AW'(rg);
  endtask

  task automatic push(input string nm, input int p, input int r, input logic hit,
                      input int pipe, input int stage, input logic stall);
    exp_t e;
    e.nm = nm; e.p = p; e.r = r; e.hit = hit;
    e.pipe = PW'(pipe); e.stage = SW'(stage); e.stall = stall;
    sb.push_back(e);
  endtask

  // Advance one clock; the stats model counts hazard edges that are not externally held.
  task automatic step();
    if (cyc_stall && !bus.stall_in) exp_cnt = exp_cnt + 32'd1;
    cyc_stall = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr();
    sb.delete();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    exp_cnt   = '0;
    cyc_stall = 1'b0;
  endtask

  task automatic test_reset();
    clr();
    rd(0, SRC_RA, 0);
    rd(1, SRC_RC, 0);
    #2;
    n_vec++;
    if (bus.fw_hit !== '0) begin n_err++; $display("FAIL reset_fw_hit: got %b want 0", bus.fw_hit); end
    n_vec++;
    if (bus.fw_pipe !== '0) begin n_err++; $display("FAIL reset_fw_pipe: got %b want 0", bus.fw_pipe); end
    n_vec++;
    if (bus.fw_stage !== '0) begin n_err++; $display("FAIL reset_fw_stage: got %b want 0", bus.fw_stage); end
    n_vec++;
    if (bus.hazard_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", bus.hazard_stall); end
`ifdef SPU_FWD_SB_STATS_EN
    n_vec++;
    if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr();
  endtask

  task automatic test_hazard();
    exp_t e;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      clr();
      case (c)
        0: issue(0, 5, 2);
        1: begin rd(1, SRC_RA, 5); push("haz_blocked", 1, SRC_RA, 0, 0, 0, 1); end
        2: begin rd(1, SRC_RA, 5); push("haz_resolved", 1, SRC_RA, 1, 0, 2, 0); end
        default: begin rd(0, SRC_RB, 5); push("haz_stage3", 0, SRC_RB, 1, 0, 3, 0); end
      endcase
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        cyc_stall = e.stall;
        if (bus.fw_hit[e.p][e.r] !== e.hit || bus.fw_pipe[e.p][e.r] !== e.pipe ||
            bus.fw_stage[e.p][e.r] !== e.stage || bus.hazard_stall !== e.stall) begin
          n_err++;
          $display("FAIL %s c%0d: hit/pipe/stage/stall got %b/%0d/%0d/%b want %b/%0d/%0d/%b",
                   e.nm, c, bus.fw_hit[e.p][e.r], bus.fw_pipe[e.p][e.r], bus.fw_stage[e.p][e.r],
                   bus.hazard_stall, e.hit, e.pipe, e.stage, e.stall);
        end
      end
      step();
    end
  endtask

  task automatic test_youngest();
    exp_t e;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      clr();
      case (c)
        0: issue(0, 9, 0);
        1: begin rd(0, SRC_RB, 9); push("lat0_ready", 0, SRC_RB, 1, 0, 1, 0); end
        3: begin
          rd(1, SRC_RB, 9); push("old_ready", 1, SRC_RB, 1, 0, 3, 0);
          issue(1, 9, 6);
        end
        4: begin
          rd(0, SRC_RB, 9); push("young_blocks", 0, SRC_RB, 0, 0, 0, 1);
          rd(1, SRC_RA, 4); push("no_match_stall", 1, SRC_RA, 0, 0, 0, 1);
          issue(0, 20, 0);
        end
        5: begin rd(0, SRC_RA, 20); push("issue_bubbled", 0, SRC_RA, 0, 0, 0, 0); end
        8: begin rd(0, SRC_RB, 9); push("still_blocked_s5", 0, SRC_RB, 0, 0, 0, 1); end
        9: begin rd(0, SRC_RB, 9); push("odd_ready_s6", 0, SRC_RB, 1, 1, 6, 0); end
        10: begin rd(0, SRC_RC, 9); push("odd_s7", 0, SRC_RC, 1, 1, 7, 0); end
        11: begin rd(0, SRC_RB, 9); push("retired", 0, SRC_RB, 0, 0, 0, 0); end
        default: ;
      endcase
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        cyc_stall = e.stall;
        if (bus.fw_hit[e.p][e.r] !== e.hit || bus.fw_pipe[e.p][e.r] !== e.pipe ||
            bus.fw_stage[e.p][e.r] !== e.stage || bus.hazard_stall !== e.stall) begin
          n_err++;
          $display("FAIL %s c%0d: hit/pipe/stage/stall got %b/%0d/%0d/%b want %b/%0d/%0d/%b",
                   e.nm, c, bus.fw_hit[e.p][e.r], bus.fw_pipe[e.p][e.r], bus.fw_stage[e.p][e.r],
                   bus.hazard_stall, e.hit, e.pipe, e.stage, e.stall);
        end
      end
      step();
    end
  endtask

  task automatic test_same_stage();
    exp_t e;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      clr();
      case (c)
        0: begin issue(0, 3, 1); issue(1, 3, 2); end
        1: begin rd(0, SRC_RA, 3); push("odd_young_blocked", 0, SRC_RA, 0, 0, 0, 1); end
        default: begin
          rd(0, SRC_RC, 3); push("odd_wins_s2", 0, SRC_RC, 1, 1, 2, 0);
          rd(1, SRC_RB, 3); push("odd_wins_s2_p1", 1, SRC_RB, 1, 1, 2, 0);
        end
      endcase
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        cyc_stall = e.stall;
        if (bus.fw_hit[e.p][e.r] !== e.hit || bus.fw_pipe[e.p][e.r] !== e.pipe ||
            bus.fw_stage[e.p][e.r] !== e.stage || bus.hazard_stall !== e.stall) begin
          n_err++;
          $display("FAIL %s c%0d: hit/pipe/stage/stall got %b/%0d/%0d/%b want %b/%0d/%0d/%b",
                   e.nm, c, bus.fw_hit[e.p][e.r], bus.fw_pipe[e.p][e.r], bus.fw_stage[e.p][e.r],
                   bus.hazard_stall, e.hit, e.pipe, e.stage, e.stall);
        end
      end
      step();
    end
  endtask

  task automatic test_flush();
    exp_t e;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      clr();
      case (c)
        0: issue(0, 11, 0);
        2: issue(0, 7, 4);
        3: begin
          bus.flush = 1'b1;
          issue(1, 13, 0);
          rd(0, SRC_RA, 11); push("pre_flush_s3", 0, SRC_RA, 1, 0, 3, 0);
        end
        4: begin
          rd(1, SRC_RC, 7);  push("flushed_gone", 1, SRC_RC, 0, 0, 0, 0);
          rd(0, SRC_RA, 11); push("survivor_s4", 0, SRC_RA, 1, 0, 4, 0);
          rd(0, SRC_RB, 13); push("flush_kills_issue", 0, SRC_RB, 0, 0, 0, 0);
        end
        5: begin issue(0, 15, 0); rd(1, SRC_RB, 11); push("survivor_s5", 1, SRC_RB, 1, 0, 5, 0); end
        6: begin
          bus.stall_in = 1'b1;
          bus.flush    = 1'b1;
          rd(1, SRC_RA, 15); push("pre_stflush_s1", 1, SRC_RA, 1, 0, 1, 0);
          rd(0, SRC_RC, 11); push("pre_stflush_s6", 0, SRC_RC, 1, 0, 6, 0);
        end
        7: begin
          rd(1, SRC_RA, 15); push("stflush_gone", 1, SRC_RA, 0, 0, 0, 0);
          rd(0, SRC_RC, 11); push("stflush_held_s6", 0, SRC_RC, 1, 0, 6, 0);
        end
        8: begin rd(0, SRC_RC, 11); push("resume_s7", 0, SRC_RC, 1, 0, 7, 0); end
        default: ;
      endcase
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        cyc_stall = e.stall;
        if (bus.fw_hit[e.p][e.r] !== e.hit || bus.fw_pipe[e.p][e.r] !== e.pipe ||
            bus.fw_stage[e.p][e.r] !== e.stage || bus.hazard_stall !== e.stall) begin
          n_err++;
          $display("FAIL %s c%0d: hit/pipe/stage/stall got %b/%0d/%0d/%b want %b/%0d/%0d/%b",
                   e.nm, c, bus.fw_hit[e.p][e.r], bus.fw_pipe[e.p][e.r], bus.fw_stage[e.p][e.r],
                   bus.hazard_stall, e.hit, e.pipe, e.stage, e.stall);
        end
      end
      step();
    end
  endtask

  task automatic test_stall();
    exp_t e;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      clr();
      case (c)
        0: issue(0, 21, 3);
        1, 2, 3: begin
          bus.stall_in = 1'b1;
          rd(1, SRC_RA, 21); push("held_blocked", 1, SRC_RA, 0, 0, 0, 1);
        end
        4: begin rd(1, SRC_RA, 21); push("frozen_s1", 1, SRC_RA, 0, 0, 0, 1); end
        5: begin rd(1, SRC_RA, 21); push("blocked_s2", 1, SRC_RA, 0, 0, 0, 1); end
        default: begin rd(1, SRC_RA, 21); push("ready_s3", 1, SRC_RA, 1, 0, 3, 0); end
      endcase
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        cyc_stall = e.stall;
        if (bus.fw_hit[e.p][e.r] !== e.hit || bus.fw_pipe[e.p][e.r] !== e.pipe ||
            bus.fw_stage[e.p][e.r] !== e.stage || bus.hazard_stall !== e.stall) begin
          n_err++;
          $display("FAIL %s c%0d: hit/pipe/stage/stall got %b/%0d/%0d/%b want %b/%0d/%0d/%b",
                   e.nm, c, bus.fw_hit[e.p][e.r], bus.fw_pipe[e.p][e.r], bus.fw_stage[e.p][e.r],
                   bus.hazard_stall, e.hit, e.pipe, e.stage, e.stall);
        end
      end
`ifdef SPU_FWD_SB_STATS_EN
      n_vec++;
      if (stall_cnt !== exp_cnt) begin
        n_err++;
        $display("FAIL stall_cnt c%0d: got %0d want %0d", c, stall_cnt, exp_cnt);
      end
`endif
      step();
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      clr();
      case (c)
        0: issue(0, 30, 5);
        1: begin rd(1, SRC_RA, 30); push("pre_reset_blocked", 1, SRC_RA, 0, 0, 0, 1); end
        2: issue(0, 127, 0);
        3: begin rd(1, SRC_RC, 127); push("max_reg_s1", 1, SRC_RC, 1, 0, 1, 0); end
        9: begin rd(1, SRC_RC, 127); push("max_reg_s7", 1, SRC_RC, 1, 0, 7, 0); end
        10: begin rd(1, SRC_RC, 127); push("max_reg_retired", 1, SRC_RC, 0, 0, 0, 0); end
        default: ;
      endcase
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        cyc_stall = e.stall;
        if (bus.fw_hit[e.p][e.r] !== e.hit || bus.fw_pipe[e.p][e.r] !== e.pipe ||
            bus.fw_stage[e.p][e.r] !== e.stage || bus.hazard_stall !== e.stall) begin
          n_err++;
          $display("FAIL %s c%0d: hit/pipe/stage/stall got %b/%0d/%0d/%b want %b/%0d/%0d/%b",
                   e.nm, c, bus.fw_hit[e.p][e.r], bus.fw_pipe[e.p][e.r], bus.fw_stage[e.p][e.r],
                   bus.hazard_stall, e.hit, e.pipe, e.stage, e.stall);
        end
      end
      if (c == 1) begin
        // Asynchronous reset between clock edges, with the blocked read still applied.
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.hazard_stall !== 1'b0 || bus.fw_hit !== '0 || bus.fw_pipe !== '0 || bus.fw_stage !== '0) begin
          n_err++;
          $display("FAIL async_reset: stall/hit/pipe/stage got %b/%b/%b/%b want all 0",
                   bus.hazard_stall, bus.fw_hit, bus.fw_pipe, bus.fw_stage);
        end
`ifdef SPU_FWD_SB_STATS_EN
        n_vec++;
        if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL async_reset_cnt: got %0d want 0", stall_cnt); end
`endif
        rst_n     = 1'b1;
        exp_cnt   = '0;
        cyc_stall = 1'b0;
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_hazard();
    test_youngest();
    test_same_stage();
    test_flush();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
